lcd_hd44780_responder: RTL and testbench

- Bus-functional responder for the HD44780 parallel interface: the panel-side counterpart of the team's LCD driver.
- Samples LCD_EN/LCD_RS/LCD_DATA on the CLOCK_50 domain and decodes instructions and data writes.
- Maintains a 2x40 DDRAM image, address counter and display-control flags, and exposes the visible 2x16 window as a 256-bit characters bus.
- Used in simulation and on-board for loopback checking of the driver and for mirroring LCD text to other outputs.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_ddram.sv | 32 +++
 rtl/lcd_hd44780_responder.sv | 115 +++++++++++
 tb/tb_lcd_hd44780_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 constants and DDRAM address helpers, used by both the LCD driver and this responder.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam int         LINE_LEN   = 40;
  localparam int         VIS_LEN    = 16;
  localparam int         NUM_CELLS  = 2 * LINE_LEN;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Step AC by one, wrapping between the two 40-cell line segments.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == LINE1_BASE + 7'(LINE_LEN - 1)) r = 7'h00;
      else if (ac == 7'(LINE_LEN - 1))         r = LINE1_BASE;
      else                                     r = ac + 7'd1;
    end else begin
      if (ac == 7'h00)           r = LINE1_BASE + 7'(LINE_LEN - 1);
      else if (ac == LINE1_BASE) r = 7'(LINE_LEN - 1);
      else                       r = ac - 7'd1;
    end
    return r;
  endfunction

  // Linear cell index 0-79 for a valid AC value.
  function automatic logic [6:0] ac_to_cell(input logic [6:0] ac);
    return (ac < LINE1_BASE) ? ac : (ac - LINE1_BASE + 7'(LINE_LEN));
  endfunction

  // Addresses in the gap after either line collapse to 0x00.
  function automatic logic [6:0] ac_sanitize(input logic [6:0] addr);
    return (addr[5:0] < 6'(LINE_LEN)) ? addr : 7'h00;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80-cell display RAM: single write port, one-cycle clear to spaces, and the visible 2x16 window flattened to 256 bits.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         we,
  input  logic [6:0]   waddr,
  input  logic [7:0]   wdata,
  output logic [255:0] characters
);

  logic [7:0] mem [0:NUM_CELLS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CELLS; i++) mem[i] <= CHAR_SPACE;
    end else if (clr) begin
      for (int i = 0; i < NUM_CELLS; i++) mem[i] <= CHAR_SPACE;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Bytes 0-15 come from line 0, bytes 16-31 from the start of line 1.
  for (genvar k = 0; k < 2 * VIS_LEN; k++) begin : g_vis
    localparam int CELL = (k < VIS_LEN) ? k : (LINE_LEN + k - VIS_LEN);
    assign characters[k*8 +: 8] = mem[CELL];
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel-side HD44780 model: detects LCD_EN falling edges, decodes instructions and data writes,
// keeps AC, display flags and an emulated busy time.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000,
  parameter int CNT_W        = 17
) (
  input  logic         CLOCK_50,
  input  logic         Reset,
  input  logic         LCD_EN,
  input  logic         LCD_RS,
  input  logic [7:0]   LCD_DATA,
  output logic [255:0] characters,
  output logic [6:0]   addr_counter,
  output logic         display_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         two_line,
  output logic         busy,
  output logic         busy_violation,
  output logic         cmd_strobe
);

  // Transfer protocol: there is no back-pressure. A transfer is the cycle in which the registered
  // LCD_EN is high and the live LCD_EN is low; RS/DATA are sampled then, effects land one edge later.
  logic             en_d;
  logic             fall;
  logic [CNT_W-1:0] busy_cnt;
  logic             inc_dec;

  logic [6:0] ac_nxt;
  logic       inc_dec_nxt, display_on_nxt, cursor_on_nxt, blink_on_nxt, two_line_nxt;
  logic       ram_we, ram_clr, long_op;

  assign fall = en_d & ~LCD_EN;
  assign busy = (busy_cnt != '0);

  always_comb begin
    ac_nxt         = addr_counter;
    inc_dec_nxt    = inc_dec;
    display_on_nxt = display_on;
    cursor_on_nxt  = cursor_on;
    blink_on_nxt   = blink_on;
    two_line_nxt   = two_line;
    ram_we         = 1'b0;
    ram_clr        = 1'b0;
    long_op        = 1'b0;
    if (fall) begin
      if (LCD_RS) begin
        ram_we = 1'b1;
        ac_nxt = ac_step(addr_counter, inc_dec);
      end else if (LCD_DATA >= CMD_DDRAM) begin
        ac_nxt = ac_sanitize(LCD_DATA[6:0]);
      end else if (LCD_DATA >= CMD_CGRAM) begin
        ac_nxt = addr_counter;
      end else if (LCD_DATA >= CMD_FUNC) begin
        two_line_nxt = LCD_DATA[3];
      end else if (LCD_DATA >= CMD_SHIFT) begin
        if (!LCD_DATA[3]) ac_nxt = ac_step(addr_counter, LCD_DATA[2]);
      end else if (LCD_DATA >= CMD_DISPCTL) begin
        {display_on_nxt, cursor_on_nxt, blink_on_nxt} = LCD_DATA[2:0];
      end else if (LCD_DATA >= CMD_ENTRY) begin
        inc_dec_nxt = LCD_DATA[1];
      end else if (LCD_DATA >= CMD_HOME) begin
        ac_nxt  = 7'h00;
        long_op = 1'b1;
      end else if (LCD_DATA == CMD_CLEAR) begin
        ac_nxt      = 7'h00;
        inc_dec_nxt = 1'b1;
        ram_clr     = 1'b1;
        long_op     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      en_d           <= 1'b0;
      addr_counter   <= 7'h00;
      inc_dec        <= 1'b1;
      display_on     <= 1'b0;
      cursor_on      <= 1'b0;
      blink_on       <= 1'b0;
      two_line       <= 1'b0;
      busy_cnt       <= '0;
      busy_violation <= 1'b0;
      cmd_strobe     <= 1'b0;
    end else begin
      en_d           <= LCD_EN;
      addr_counter   <= ac_nxt;
      inc_dec        <= inc_dec_nxt;
      display_on     <= display_on_nxt;
      cursor_on      <= cursor_on_nxt;
      blink_on       <= blink_on_nxt;
      two_line       <= two_line_nxt;
      cmd_strobe     <= fall;
      busy_violation <= fall & busy;
      if (fall)      busy_cnt <= long_op ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
      else if (busy) busy_cnt <= busy_cnt - 1'b1;
    end
  end

  lcd_ddram u_ddram (
    .clk        (CLOCK_50),
    .rst        (Reset),
    .clr        (ram_clr),
    .we         (ram_we),
    .waddr      (ac_to_cell(addr_counter)),
    .wdata      (LCD_DATA),
    .characters (characters)
  );

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: one task per feature, inline checks, single summary line.
module tb_lcd_hd44780_responder;

  logic         CLOCK_50 = 1'b0;
  logic         Reset;
  logic         LCD_EN;
  logic         LCD_RS;
  logic [7:0]   LCD_DATA;
  logic [255:0] characters;
  logic [6:0]   addr_counter;
  logic         display_on, cursor_on, blink_on, two_line;
  logic         busy, busy_violation, cmd_strobe;

  int   checks = 0;
  int   passed = 0;
  logic got_strobe, got_viol;

  lcd_hd44780_responder dut (
    .CLOCK_50       (CLOCK_50),
    .Reset          (Reset),
    .LCD_EN         (LCD_EN),
    .LCD_RS         (LCD_RS),
    .LCD_DATA       (LCD_DATA),
    .characters     (characters),
    .addr_counter   (addr_counter),
    .display_on     (display_on),
    .cursor_on      (cursor_on),
    .blink_on       (blink_on),
    .two_line       (two_line),
    .busy           (busy),
    .busy_violation (busy_violation),
    .cmd_strobe     (cmd_strobe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Inputs change on the falling clock edge; outputs are sampled one full cycle after the transfer.
  task automatic xfer(input logic rs, input logic [7:0] d);
    @(negedge CLOCK_50);
    LCD_RS = rs; LCD_DATA = d; LCD_EN = 1'b1;
    @(negedge CLOCK_50);
    LCD_EN = 1'b0;
    @(negedge CLOCK_50);
    got_strobe = cmd_strobe;
    got_viol   = busy_violation;
  endtask

  task automatic test_reset();
    Reset = 1'b1; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_DATA = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    checks++; if (characters !== {32{8'h20}}) $display("FAIL reset_chars got=%h exp=all 20", characters); else passed++;
    checks++; if (addr_counter !== 7'h00) $display("FAIL reset_ac got=%h exp=00", addr_counter); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if ({display_on, cursor_on, blink_on, two_line} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {display_on, cursor_on, blink_on, two_line}); else passed++;
    checks++; if ({cmd_strobe, busy_violation} !== 2'b00)
      $display("FAIL reset_pulses got=%b exp=00", {cmd_strobe, busy_violation}); else passed++;
  endtask

  task automatic test_write_hi();
    int strobes;
    strobes = 0;
    xfer(1'b0, 8'h80);
    xfer(1'b1, 8'h48); strobes += int'(got_strobe);
    xfer(1'b1, 8'h69); strobes += int'(got_strobe);
    checks++; if (characters[7:0] !== 8'h48) $display("FAIL hi_byte0 got=%h exp=48", characters[7:0]); else passed++;
    checks++; if (characters[15:8] !== 8'h69) $display("FAIL hi_byte1 got=%h exp=69", characters[15:8]); else passed++;
    checks++; if (addr_counter !== 7'h02) $display("FAIL hi_ac got=%h exp=02", addr_counter); else passed++;
    checks++; if (strobes !== 2) $display("FAIL hi_strobes got=%0d exp=2", strobes); else passed++;
  endtask

  task automatic test_line2_wrap();
    xfer(1'b0, 8'hC0);
    for (int i = 0; i < 17; i++) xfer(1'b1, 8'h41);
    checks++; if (characters[255:128] !== {16{8'h41}}) $display("FAIL line2_bytes got=%h exp=all 41", characters[255:128]); else passed++;
    checks++; if (addr_counter !== 7'h51) $display("FAIL line2_ac got=%h exp=51", addr_counter); else passed++;
    xfer(1'b0, 8'hA7);
    checks++; if (addr_counter !== 7'h27) $display("FAIL set_27 got=%h exp=27", addr_counter); else passed++;
    xfer(1'b1, 8'h42);
    checks++; if (addr_counter !== 7'h40) $display("FAIL wrap_27_40 got=%h exp=40", addr_counter); else passed++;
    xfer(1'b0, 8'hE7);
    xfer(1'b1, 8'h43);
    checks++; if (addr_counter !== 7'h00) $display("FAIL wrap_67_00 got=%h exp=00", addr_counter); else passed++;
  endtask

  task automatic test_entry_dec();
    xfer(1'b0, 8'h04);
    xfer(1'b0, 8'h80);
    xfer(1'b1, 8'h5A);
    checks++; if (characters[7:0] !== 8'h5A) $display("FAIL dec_byte0 got=%h exp=5a", characters[7:0]); else passed++;
    checks++; if (addr_counter !== 7'h67) $display("FAIL dec_wrap_ac got=%h exp=67", addr_counter); else passed++;
    xfer(1'b0, 8'hC0);
    xfer(1'b1, 8'h44);
    checks++; if (addr_counter !== 7'h27) $display("FAIL dec_wrap_40_27 got=%h exp=27", addr_counter); else passed++;
    xfer(1'b0, 8'h06);
  endtask

  task automatic test_instr();
    xfer(1'b0, 8'h0E);
    checks++; if ({display_on, cursor_on, blink_on} !== 3'b110)
      $display("FAIL dispctl got=%b exp=110", {display_on, cursor_on, blink_on}); else passed++;
    xfer(1'b0, 8'h28);
    checks++; if (two_line !== 1'b1) $display("FAIL func_set got=%b exp=1", two_line); else passed++;
    xfer(1'b0, 8'h85);
    xfer(1'b0, 8'hA8);
    checks++; if (addr_counter !== 7'h00) $display("FAIL ddram_gap got=%h exp=00", addr_counter); else passed++;
    xfer(1'b0, 8'h10);
    checks++; if (addr_counter !== 7'h67) $display("FAIL shift_left got=%h exp=67", addr_counter); else passed++;
    xfer(1'b0, 8'h14);
    checks++; if (addr_counter !== 7'h00) $display("FAIL shift_right got=%h exp=00", addr_counter); else passed++;
    xfer(1'b0, 8'h85);
    xfer(1'b0, 8'h18);
    xfer(1'b0, 8'h45);
    checks++; if (addr_counter !== 7'h05) $display("FAIL ignored_ops_ac got=%h exp=05", addr_counter); else passed++;
    xfer(1'b0, 8'h02);
    checks++; if (addr_counter !== 7'h00) $display("FAIL home got=%h exp=00", addr_counter); else passed++;
    xfer(1'b0, 8'h00);
    checks++; if (got_strobe !== 1'b1) $display("FAIL nop_strobe got=%b exp=1", got_strobe); else passed++;
  endtask

  task automatic test_clear_busy();
    int n;
    xfer(1'b0, 8'h04);
    xfer(1'b0, 8'h83);
    xfer(1'b0, 8'h01);
    checks++; if (characters !== {32{8'h20}}) $display("FAIL clear_chars got=%h exp=all 20", characters); else passed++;
    checks++; if (addr_counter !== 7'h00) $display("FAIL clear_ac got=%h exp=00", addr_counter); else passed++;
    n = 0;
    while (busy && n < 90000) begin
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (n !== 82000) $display("FAIL clear_busy_len got=%0d exp=82000", n); else passed++;
    xfer(1'b1, 8'h41);
    checks++; if (addr_counter !== 7'h01) $display("FAIL clear_restores_inc got=%h exp=01", addr_counter); else passed++;
    checks++; if (got_viol !== 1'b0) $display("FAIL idle_no_violation got=%b exp=0", got_viol); else passed++;
  endtask

  task automatic test_violation();
    int n;
    xfer(1'b0, 8'h01);
    repeat (99) @(negedge CLOCK_50);
    xfer(1'b0, 8'h0C);
    checks++; if (got_viol !== 1'b1) $display("FAIL violation_pulse got=%b exp=1", got_viol); else passed++;
    checks++; if ({display_on, cursor_on, blink_on} !== 3'b100)
      $display("FAIL violation_exec got=%b exp=100", {display_on, cursor_on, blink_on}); else passed++;
    @(negedge CLOCK_50);
    checks++; if (busy_violation !== 1'b0) $display("FAIL violation_one_cycle got=%b exp=0", busy_violation); else passed++;
    n = 1;
    while (busy && n < 5000) begin
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (n !== 2000) $display("FAIL reload_len got=%0d exp=2000", n); else passed++;
  endtask

  task automatic test_reset_mid_busy();
    xfer(1'b1, 8'h5A);
    repeat (5) @(negedge CLOCK_50);
    checks++; if (busy !== 1'b1) $display("FAIL pre_reset_busy got=%b exp=1", busy); else passed++;
    #3 Reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL async_reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (characters !== {32{8'h20}}) $display("FAIL async_reset_chars got=%h exp=all 20", characters); else passed++;
    @(negedge CLOCK_50);
    Reset = 1'b0;
    @(negedge CLOCK_50);
    checks++; if ({addr_counter, display_on, two_line} !== 9'h000)
      $display("FAIL post_reset_state got=%h exp=000", {addr_counter, display_on, two_line}); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_hi();
    test_line2_wrap();
    test_entry_dec();
    test_instr();
    test_clear_busy();
    test_violation();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
